bin2bcd_display_conv: RTL and testbench
=======================================

Name: bin2bcd_display_conv

Overview:
- Converts the 16-bit binary count from the temperature gate-time counter into packed BCD digits for the 4-digit 7-segment scanner.
- Sits between the counter's Dout and the scanner's DataIn_A..D nibbles.
- Uses an iterative shift-add-3 (double-dabble) engine with a valid/ready input handshake, registered held outputs, saturation and leading-zero blanking.

Parameters:
- DATA_W, 16, width of the binary input.
- N_DIGITS, 4, number of BCD output digits. Saturation limit is 10^N_DIGITS-1.
- SAT_VAL, 9999, decimal saturation limit. Must equal 10^N_DIGITS-1. Checked by an elaboration assertion.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- bin_in  in  DATA_W  binary value to convert.
- in_valid  in  1  bin_in is valid.
- in_ready  out  1  converter idle; a transfer occurs when in_valid and in_ready are both 1 at a rising edge.
- bcd_out  out  4*N_DIGITS  packed BCD. Digit 0 (units) is bits [3:0].
- blank  out  N_DIGITS  leading-zero blanking mask, one bit per digit.
- ovf  out  1  last accepted value exceeded SAT_VAL.
- out_valid  out  1  one-cycle pulse: bcd_out, blank and ovf were just updated.

Behaviour:
- Reset values (rst=0, asynchronous):
  - state=IDLE, in_ready=1, bcd_out=0, blank={N_DIGITS-1{1},0}, ovf=0, out_valid=0.
  - All internal shift registers and the iteration counter are cleared.
- States: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On transfer with bin_in > SAT_VAL: go to DONE; load saturated digits (all 9) into the result register; pending ovf=1.
  - On transfer otherwise: go to CONV; load bin_in into the binary shift register; clear the BCD working register and counter; pending ovf=0.
- CONV:
  - in_ready=0.
  - Each cycle: every working digit >=5 has 3 added, then {bcd,bin} is shifted left by 1.
  - Counter increments each cycle. After exactly DATA_W CONV cycles, go to DONE.
  - The working register is 4*N_DIGITS bits wide. This is sufficient because the input is <=SAT_VAL, so no digit carry is lost.
- DONE (one cycle):
  - in_ready=0.
  - At its closing edge: bcd_out, blank and ovf are registered from the working register and pending flag; out_valid=1 for the following cycle only; go to IDLE.
- Latency from the transfer edge to out_valid high:
  - DATA_W+2 edges on the normal path (17 cycles of CONV+DONE after accept, out_valid visible in the 18th cycle).
  - 2 edges on the saturated path.
  - Fixed and independent of value.
- out_valid coincides with IDLE, so a new transfer may occur in the same cycle out_valid is high (back-to-back throughput DATA_W+2 cycles).
- in_valid while not in IDLE is ignored. No queuing; bin_in is sampled only at the transfer edge.
- bcd_out, blank and ovf hold their values between updates. The scanner may read them at any time without tearing.
- blank[i], for i>=1: set iff digit i and all higher digits are 0. blank[0] is always 0 (value 0 shows "0").
- Reset mid-conversion: abort immediately to reset values; no out_valid is produced for the aborted value.
- All arithmetic is unsigned. The add-3 correction is 4-bit and never overflows, since digits are <=9 before correction.

Decomposition:
- Shared package bcd_pkg:
  - state enum (IDLE/CONV/DONE).
  - DIGIT_W=4.
  - constants ADD3_THRESH=5, ADD3_VAL=3.
  - function computing 10^N-1 for the SAT_VAL check.
- One combinational sub-module, bcd_digit_adj: 4-bit in, 4-bit out, adds 3 if the input is >=5. Instantiated N_DIGITS times by generate in the CONV datapath.

Test Plan:
- Reset then bin_in=0, in_valid pulse → out_valid exactly 18 cycles after accept, bcd_out=0x0000, blank=4'b1110, ovf=0.
- bin_in=1234 (0x04D2) → bcd_out=0x1234, blank=4'b0000, ovf=0. in_ready is low for exactly 17 cycles after accept.
- bin_in=9999 → bcd_out=0x9999, ovf=0. Then bin_in=10000 → bcd_out=0x9999, ovf=1, out_valid on the 2nd edge after accept. Then bin_in=65535 → same result.
- bin_in=7 accepted; in_valid held high with bin_in=500 during CONV → the 500 is ignored, bcd_out=0x0007, blank=4'b1110. The 500 is accepted in the out_valid cycle and yields 0x0500, blank=4'b1000.
- Accept bin_in=4321, assert rst=0 at CONV cycle 8 → all outputs return to reset values immediately and no out_valid occurs. After release, bin_in=42 → 0x0042.
- Random sweep of 0..65535 against a reference model → bcd_out equals min(v,9999) in BCD, ovf=(v>9999), blank per rule, fixed latency.

Source files
------------

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the binary-to-BCD display converter
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } conv_state_t;

   localparam int DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] ADD3_THRESH = 4'd5;
   localparam logic [DIGIT_W-1:0] ADD3_VAL    = 4'd3;

   function automatic int pow10_minus1(input int n);
      int p;
      p = 1;
      for (int i = 0; i < n; i++) begin
         p = p * 10;
      end
      return p - 1;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble digit correction: add 3 when the digit is 5 or more
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit_in,
   output logic [DIGIT_W-1:0] digit_out
);

   assign digit_out = (digit_in >= ADD3_THRESH) ? digit_in + ADD3_VAL : digit_in;

endmodule

// File: rtl/bin2bcd_display_conv.sv
// rtl/bin2bcd_display_conv.sv - iterative binary-to-BCD converter with saturation and leading-zero blanking
module bin2bcd_display_conv
   import bcd_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int N_DIGITS = 4,
   parameter int SAT_VAL  = 9999
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [DATA_W-1:0]           bin_in,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic [DIGIT_W*N_DIGITS-1:0] bcd_out,
   output logic [N_DIGITS-1:0]         blank,
   output logic                        ovf,
   output logic                        out_valid
);

   localparam int BCD_W = DIGIT_W * N_DIGITS;
   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [DATA_W-1:0]   SAT_BIN     = DATA_W'(SAT_VAL);
   localparam logic [CNT_W-1:0]    LAST_CNT    = CNT_W'(DATA_W - 1);
   localparam logic [BCD_W-1:0]    ALL_NINES   = {N_DIGITS{4'h9}};
   localparam logic [N_DIGITS-1:0] BLANK_RESET = {{(N_DIGITS-1){1'b1}}, 1'b0};

   if (SAT_VAL != pow10_minus1(N_DIGITS)) begin : g_sat_check
      $error("SAT_VAL must equal 10**N_DIGITS-1");
   end

   conv_state_t       state;
   conv_state_t       next_state;
   logic [DATA_W-1:0] bin_sr;
   logic [BCD_W-1:0]  bcd_work;
   logic [BCD_W-1:0]  bcd_adj;
   logic [CNT_W-1:0]  cnt;
   logic              ovf_pend;
   logic              transfer;
   logic              over_sat;
   logic [N_DIGITS-1:0] blank_next;
   logic              zero_run;

   for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit_in  (bcd_work[g*DIGIT_W +: DIGIT_W]),
         .digit_out (bcd_adj[g*DIGIT_W +: DIGIT_W])
      );
   end

   assign transfer = in_valid && in_ready;
   assign over_sat = (bin_in > SAT_BIN);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               next_state = over_sat ? DONE : CONV;
            end
         end
         CONV: begin
            if (cnt == LAST_CNT) begin
               next_state = DONE;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // A digit is blanked only if it and every more significant digit are zero.
   always_comb begin
      blank_next = '0;
      zero_run   = 1'b1;
      for (int i = N_DIGITS - 1; i >= 1; i--) begin
         zero_run      = zero_run && (bcd_work[i*DIGIT_W +: DIGIT_W] == '0);
         blank_next[i] = zero_run;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bin_sr    <= '0;
         bcd_work  <= '0;
         cnt       <= '0;
         ovf_pend  <= 1'b0;
         bcd_out   <= '0;
         blank     <= BLANK_RESET;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (transfer) begin
                  if (over_sat) begin
                     bcd_work <= ALL_NINES;
                     ovf_pend <= 1'b1;
                  end else begin
                     bin_sr   <= bin_in;
                     bcd_work <= '0;
                     cnt      <= '0;
                     ovf_pend <= 1'b0;
                  end
               end
            end
            CONV: begin
               // The top bit shifted out is always zero since the input never exceeds SAT_VAL.
               {bcd_work, bin_sr} <= {bcd_adj, bin_sr} << 1;
               cnt                <= cnt + 1'b1;
            end
            DONE: begin
               bcd_out   <= bcd_work;
               blank     <= blank_next;
               ovf       <= ovf_pend;
               out_valid <= 1'b1;
            end
            default: begin
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bin2bcd_display_conv.sv
// tb/tb_bin2bcd_display_conv.sv - scoreboard bench for bin2bcd_display_conv
module tb_bin2bcd_display_conv;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] bin_in = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] bcd_out;
   logic [3:0]  blank;
   logic        ovf;
   logic        out_valid;

   bin2bcd_display_conv #(.DATA_W(16), .N_DIGITS(4), .SAT_VAL(9999)) dut (
      .clk       (clk),
      .rst       (rst),
      .bin_in    (bin_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bcd_out   (bcd_out),
      .blank     (blank),
      .ovf       (ovf),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] bcd;
      logic [3:0]  blank;
      logic        ovf;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst && out_valid) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_out_valid: got bcd_out %0h with no pending expectation (t=%0t)", bcd_out, $time);
         end else begin
            mon_e = sb.pop_front();
            chk("bcd_out", {16'h0, bcd_out}, {16'h0, mon_e.bcd});
            chk("blank", {28'h0, blank}, {28'h0, mon_e.blank});
            chk("ovf", {31'h0, ovf}, {31'h0, mon_e.ovf});
            chk("latency", cyc - mon_e.acc, mon_e.lat);
         end
      end
   end

   task automatic push_exp(input logic [15:0] bcd, input logic [3:0] bl, input logic o, input int acc);
      exp_t e;
      e.bcd   = bcd;
      e.blank = bl;
      e.ovf   = o;
      e.lat   = o ? 2 : 18;
      e.acc   = acc;
      sb.push_back(e);
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL ready_timeout: in_ready got 0 expected 1 within 200 cycles");
      end
   endtask

   task automatic send(input logic [15:0] v, input logic [15:0] bcd, input logic [3:0] bl, input logic o);
      wait_ready();
      bin_in   = v;
      in_valid = 1'b1;
      push_exp(bcd, bl, o, cyc);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   function automatic exp_t model(input int v);
      exp_t e;
      int   s;
      int   d[4];
      s = (v > 9999) ? 9999 : v;
      d[0] = s % 10;
      d[1] = (s / 10) % 10;
      d[2] = (s / 100) % 10;
      d[3] = (s / 1000) % 10;
      e.bcd      = {d[3][3:0], d[2][3:0], d[1][3:0], d[0][3:0]};
      e.blank[3] = (d[3] == 0);
      e.blank[2] = e.blank[3] && (d[2] == 0);
      e.blank[1] = e.blank[2] && (d[1] == 0);
      e.blank[0] = 1'b0;
      e.ovf      = (v > 9999);
      e.lat      = 0;
      e.acc      = 0;
      return e;
   endfunction

   initial begin
      int   lo;
      int   n;
      int   vals[$];
      exp_t m;

      repeat (2) @(negedge clk);
      chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
      chk("rst_bcd_out", {16'h0, bcd_out}, 32'h0);
      chk("rst_blank", {28'h0, blank}, 32'he);
      chk("rst_ovf", {31'h0, ovf}, 32'h0);
      chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
      rst = 1'b1;
      @(negedge clk);

      send(16'd0, 16'h0000, 4'b1110, 1'b0);

      send(16'd1234, 16'h1234, 4'b0000, 1'b0);
      lo = 0;
      while (!in_ready && lo < 100) begin
         lo++;
         @(negedge clk);
      end
      chk("in_ready_low_cycles", lo, 17);

      send(16'd9999, 16'h9999, 4'b0000, 1'b0);
      send(16'd10000, 16'h9999, 4'b0000, 1'b1);
      send(16'd65535, 16'h9999, 4'b0000, 1'b1);

      // Hold in_valid high across the conversion of 7; 500 must wait for the next IDLE.
      wait_ready();
      bin_in   = 16'd7;
      in_valid = 1'b1;
      push_exp(16'h0007, 4'b1110, 1'b0, cyc);
      @(negedge clk);
      bin_in = 16'd500;
      wait_ready();
      chk("ready_with_out_valid", {31'h0, out_valid}, 32'h1);
      push_exp(16'h0500, 4'b1000, 1'b0, cyc);
      @(negedge clk);
      in_valid = 1'b0;

      // Abort 4321 with reset in its eighth conversion cycle.
      wait_ready();
      bin_in   = 16'd4321;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_in_ready", {31'h0, in_ready}, 32'h1);
      chk("abort_bcd_out", {16'h0, bcd_out}, 32'h0);
      chk("abort_blank", {28'h0, blank}, 32'he);
      chk("abort_ovf", {31'h0, ovf}, 32'h0);
      chk("abort_out_valid", {31'h0, out_valid}, 32'h0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      send(16'd42, 16'h0042, 4'b1100, 1'b0);

      vals = '{1, 9, 10, 99, 100, 999, 1000, 5555, 8421, 9998, 10001, 32768};
      for (int i = 0; i < 8; i++) begin
         vals.push_back(int'($urandom_range(0, 65535)));
      end
      foreach (vals[i]) begin
         m = model(vals[i]);
         send(16'(vals[i]), m.bcd, m.blank, m.ovf);
      end

      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboard_drained", sb.size(), 0);
      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
